feature_rect_summer: RTL and testbench

Downstream consumer of the feature cache in the openCV detection pipeline. On `start` it walks features `0..NUM_FEATURES-1`. For each feature it:
- reads the four packed X,Y corner words from the feature cache;
- fetches the matching integral-image values from the window cache;
- emits the signed rectangle sum `A - B - C + D` on a valid/ready output.

It feeds the classifier/threshold stage.

---
 rtl/pkg_featureRectSum.sv | 26 ++
 rtl/feature_corner_acc.sv | 61 ++++++
 rtl/feature_rect_summer.sv | 174 +++++++++++++++++
 tb/tb_feature_rect_summer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_featureRectSum.sv
`default_nettype none
// ============================================================================
//  Module   : pkg_featureRectSum
//  Purpose  : Shared types, FSM encodings and corner signs for feature_rect_summer.
//  Revision : 1.0  initial release
// ============================================================================
package pkg_featureRectSum;

    localparam int c_window_bits = 5;
    localparam int c_pix_bits    = 18;

    typedef logic [c_window_bits-1:0]        coord_t;
    typedef logic signed [c_pix_bits+1:0]    rect_sum_t;
    typedef logic [2:0]                      state_t;

    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_issue = 3'd1;
    localparam state_t c_st_drain = 3'd2;
    localparam state_t c_st_out   = 3'd3;
    localparam state_t c_st_done  = 3'd4;

    // 1 = corner is subtracted; order is A, B, C, D
    localparam logic c_corner_sign [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

endpackage
`default_nettype wire

// File: rtl/feature_corner_acc.sv
`default_nettype none
// ============================================================================
//  Module   : feature_corner_acc
//  Purpose  : Two-stage sign/valid pipeline following the cache reads, plus a
//             signed wrap-around accumulator with synchronous clear.
//  Revision : 1.0  initial release
// ============================================================================
module feature_corner_acc #(
    parameter int PIX_BITS = 18,
    parameter int SUM_BITS = PIX_BITS + 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_clear,
    input  logic                i_issue,
    input  logic                i_neg,
    input  logic [PIX_BITS-1:0] i_pix,
    output logic                o_rd_valid,
    output logic [SUM_BITS-1:0] o_acc_next
);

    logic                r_v1;
    logic                r_n1;
    logic                r_v2;
    logic                r_n2;
    logic [SUM_BITS-1:0] r_acc;
    logic [SUM_BITS-1:0] w_pix_ext;
    logic [SUM_BITS-1:0] w_acc_next;

    assign w_pix_ext = SUM_BITS'(i_pix);

    always_comb begin
        w_acc_next = r_acc;
        if (i_clear) begin
            w_acc_next = '0;
        end else if (r_v2) begin
            w_acc_next = r_n2 ? (r_acc - w_pix_ext) : (r_acc + w_pix_ext);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1  <= 1'b0;
            r_n1  <= 1'b0;
            r_v2  <= 1'b0;
            r_n2  <= 1'b0;
            r_acc <= '0;
        end else begin
            r_v1  <= i_issue;
            r_n1  <= i_neg;
            r_v2  <= r_v1;
            r_n2  <= r_n1;
            r_acc <= w_acc_next;
        end
    end

    assign o_rd_valid = r_v1;
    assign o_acc_next = w_acc_next;

endmodule
`default_nettype wire

// File: rtl/feature_rect_summer.sv
`default_nettype none
// ============================================================================
//  Module   : feature_rect_summer
//  Purpose  : Walks the feature cache, fetches four integral-image corners per
//             feature and emits A - B - C + D on a valid/ready port.
//             Optional FEATURE_RECT_COORD_CHECK_EN adds a sticky range flag.
//  Revision : 1.0  initial release
// ============================================================================
module feature_rect_summer
    import pkg_featureRectSum::*;
#(
    parameter int NUM_FEATURES = 16,
    parameter int WINDOW_BITS  = c_window_bits,
    parameter int WINDOW_SIZE  = 24,
    parameter int ADDR_BITS    = $clog2(NUM_FEATURES*4),
    parameter int PIX_BITS     = c_pix_bits,
    parameter int SUM_BITS     = PIX_BITS + 2
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic                                            start,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            fc_rd_en,
    output logic [ADDR_BITS-1:0]                            fc_addr,
    input  logic [2*WINDOW_BITS-1:0]                        fc_rdata,
    output logic                                            wc_rd_en,
    output logic [WINDOW_BITS-1:0]                          wc_x,
    output logic [WINDOW_BITS-1:0]                          wc_y,
    input  logic [PIX_BITS-1:0]                             wc_rdata,
    output logic                                            sum_valid,
    input  logic                                            sum_ready,
    output logic [((NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1)-1:0] sum_idx,
    output logic signed [SUM_BITS-1:0]                      rect_sum,
    output logic                                            coord_err
);

    localparam int IDX_BITS = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;

    state_t              r_state;
    logic [IDX_BITS-1:0] r_feat;
    logic [1:0]          r_k;
    logic                r_sum_valid;
    logic [SUM_BITS-1:0] r_rect_sum;
    logic [IDX_BITS-1:0] r_sum_idx;

    logic                w_issue;
    logic                w_start_ok;
    logic                w_handshake;
    logic                w_last_feat;
    logic                w_load;
    logic                w_wc_rd_en;
    logic [SUM_BITS-1:0] w_acc_next;

    generate
        if (WINDOW_SIZE > (1 << WINDOW_BITS)) begin : g_bad_window
            $error("WINDOW_SIZE does not fit in WINDOW_BITS");
        end
    endgenerate

    assign w_issue     = (r_state == c_st_issue);
    assign w_start_ok  = (r_state == c_st_idle) & start;
    assign w_handshake = r_sum_valid & sum_ready;
    assign w_last_feat = (r_feat == IDX_BITS'(NUM_FEATURES - 1));
    // Final DRAIN cycle: the last corner is landing in the accumulator now
    assign w_load      = (r_state == c_st_drain) & (r_k == 2'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_feat  <= '0;
            r_k     <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_feat  <= '0;
                        r_k     <= '0;
                        r_state <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_k <= r_k + 2'd1;
                    if (r_k == 2'd3) r_state <= c_st_drain;
                end
                c_st_drain: begin
                    if (r_k == 2'd1) begin
                        r_k     <= '0;
                        r_state <= c_st_out;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                c_st_out: begin
                    if (w_handshake) begin
                        if (w_last_feat) begin
                            r_state <= c_st_done;
                        end else begin
                            r_feat  <= r_feat + 1'b1;
                            r_state <= c_st_issue;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum_valid <= 1'b0;
            r_rect_sum  <= '0;
            r_sum_idx   <= '0;
        end else if (w_load) begin
            r_sum_valid <= 1'b1;
            r_rect_sum  <= w_acc_next;
            r_sum_idx   <= r_feat;
        end else if (w_handshake) begin
            r_sum_valid <= 1'b0;
        end
    end

    feature_corner_acc #(
        .PIX_BITS (PIX_BITS),
        .SUM_BITS (SUM_BITS)
    ) u_acc (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (w_start_ok | w_handshake),
        .i_issue    (w_issue),
        .i_neg      (c_corner_sign[r_k]),
        .i_pix      (wc_rdata),
        .o_rd_valid (w_wc_rd_en),
        .o_acc_next (w_acc_next)
    );

    assign busy      = (r_state == c_st_issue) | (r_state == c_st_drain) | (r_state == c_st_out);
    assign done      = (r_state == c_st_done);
    assign fc_rd_en  = w_issue;
    assign fc_addr   = w_issue ? ADDR_BITS'({r_feat, r_k}) : '0;
    assign wc_rd_en  = w_wc_rd_en;
    assign wc_x      = w_wc_rd_en ? fc_rdata[2*WINDOW_BITS-1:WINDOW_BITS] : '0;
    assign wc_y      = w_wc_rd_en ? fc_rdata[WINDOW_BITS-1:0] : '0;
    assign sum_valid = r_sum_valid;
    assign sum_idx   = r_sum_idx;
    assign rect_sum  = r_rect_sum;

`ifdef FEATURE_RECT_COORD_CHECK_EN
    localparam logic [WINDOW_BITS:0] c_win_limit = (WINDOW_BITS + 1)'(WINDOW_SIZE);

    logic r_coord_err;
    logic w_coord_bad;

    assign w_coord_bad = w_wc_rd_en &
                         (({1'b0, fc_rdata[2*WINDOW_BITS-1:WINDOW_BITS]} >= c_win_limit) |
                          ({1'b0, fc_rdata[WINDOW_BITS-1:0]} >= c_win_limit));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_coord_err <= 1'b0;
        end else if (w_start_ok) begin
            r_coord_err <= 1'b0;
        end else if (w_coord_bad) begin
            r_coord_err <= 1'b1;
        end
    end

    assign coord_err = r_coord_err;
`else
    assign coord_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_feature_rect_summer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_feature_rect_summer
//  Purpose  : Directed, scoreboard-based bench for feature_rect_summer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_feature_rect_summer;

    localparam int NF = 16;
    localparam int WB = 5;
    localparam int PB = 18;
    localparam int SB = 20;
    localparam int AB = 6;
    localparam int IB = 4;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    logic                 sum_ready = 1'b0;
    logic                 busy, done, fc_rd_en, wc_rd_en, sum_valid, coord_err;
    logic [AB-1:0]        fc_addr;
    logic [2*WB-1:0]      fc_rdata = '0;
    logic [WB-1:0]        wc_x, wc_y;
    logic [PB-1:0]        wc_rdata = '0;
    logic [IB-1:0]        sum_idx;
    logic signed [SB-1:0] rect_sum;

    logic [2*WB-1:0] fc_mem [NF*4];
    logic [PB-1:0]   wc_mem [1024];

    typedef struct packed {
        logic [IB-1:0] idx;
        logic [SB-1:0] sum;
    } exp_t;
    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int result_cnt = 0;
    int rd_cnt = 0;

    feature_rect_summer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .fc_rd_en  (fc_rd_en),
        .fc_addr   (fc_addr),
        .fc_rdata  (fc_rdata),
        .wc_rd_en  (wc_rd_en),
        .wc_x      (wc_x),
        .wc_y      (wc_y),
        .wc_rdata  (wc_rdata),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .sum_idx   (sum_idx),
        .rect_sum  (rect_sum),
        .coord_err (coord_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fc_rd_en) fc_rdata <= fc_mem[fc_addr];
        if (wc_rd_en) wc_rdata <= wc_mem[{wc_x, wc_y}];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SB-1:0] corner_val(input int f, input int k);
        logic [2*WB-1:0] w;
        w = fc_mem[f*4 + k];
        return SB'(wc_mem[{w[2*WB-1:WB], w[WB-1:0]}]);
    endfunction

    function automatic logic [SB-1:0] exp_sum(input int f);
        return corner_val(f, 0) - corner_val(f, 1) - corner_val(f, 2) + corner_val(f, 3);
    endfunction

    task automatic push_pass();
        exp_t e;
        for (int f = 0; f < NF; f++) begin
            e.idx = IB'(f);
            if (f == 0)      e.sum = SB'(30);
            else if (f == 1) e.sum = 20'hFFFF6;
            else             e.sum = exp_sum(f);
            sb_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("coord_err_cleared", 64'(coord_err), 64'd0);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        chk("done_seen", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd0);
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        result_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic check_pass_counts();
        @(negedge clk);
        chk("done_once", 64'(done_cnt), 64'd1);
        chk("result_cnt", 64'(result_cnt), 64'(NF));
        chk("fc_read_cnt", 64'(rd_cnt), 64'(NF * 4));
        chk("queue_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk(tag, 64'({busy, done, fc_rd_en, fc_addr, wc_rd_en, wc_x, wc_y,
                      sum_valid, sum_idx, rect_sum, coord_err}), 64'd0);
    endtask

    // Cycle monitor: scoreboard pops, address order, read timing, hold stability
    logic [AB-1:0] exp_addr = '0;
    logic          prev_fc = 1'b0;
    logic          prev_hold = 1'b0;
    logic [SB-1:0] prev_sum = '0;
    logic [IB-1:0] prev_idx = '0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            exp_addr  = '0;
            prev_fc   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            chk("wc_rd_en_delay", 64'(wc_rd_en), 64'(prev_fc));
            prev_fc = fc_rd_en;
            if (fc_rd_en) begin
                chk("fc_addr_seq", 64'(fc_addr), 64'(exp_addr));
                exp_addr = exp_addr + 1'b1;
                rd_cnt++;
            end
            if (prev_hold) begin
                chk("hold_rect_sum", {44'd0, rect_sum}, {44'd0, prev_sum});
                chk("hold_sum_idx", 64'(sum_idx), 64'(prev_idx));
            end
            if (sum_valid) chk("no_read_in_out", 64'({fc_rd_en, wc_rd_en}), 64'd0);
            prev_hold = sum_valid & ~sum_ready;
            prev_sum  = rect_sum;
            prev_idx  = sum_idx;
            if (sum_valid && sum_ready) begin
                result_cnt++;
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sum_idx", 64'(sum_idx), 64'(e.idx));
                    chk("rect_sum", {44'd0, rect_sum}, {44'd0, e.sum});
                end
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        int n1;
        int n2;
        logic [2*WB-1:0] saved;
        logic exp_ce;

        for (int i = 0; i < 1024; i++) wc_mem[i] = PB'($urandom);
        for (int i = 0; i < NF * 4; i++)
            fc_mem[i] = {WB'($urandom_range(0, 23)), WB'($urandom_range(0, 23))};
        fc_mem[0] = {5'd0, 5'd0}; fc_mem[1] = {5'd4, 5'd0};
        fc_mem[2] = {5'd0, 5'd4}; fc_mem[3] = {5'd4, 5'd4};
        fc_mem[4] = {5'd1, 5'd1}; fc_mem[5] = {5'd2, 5'd1};
        fc_mem[6] = {5'd1, 5'd2}; fc_mem[7] = {5'd2, 5'd2};
        wc_mem[{5'd0, 5'd0}] = 18'd10; wc_mem[{5'd4, 5'd0}] = 18'd30;
        wc_mem[{5'd0, 5'd4}] = 18'd50; wc_mem[{5'd4, 5'd4}] = 18'd100;
        wc_mem[{5'd1, 5'd1}] = 18'd0;  wc_mem[{5'd2, 5'd1}] = 18'd5;
        wc_mem[{5'd1, 5'd2}] = 18'd5;  wc_mem[{5'd2, 5'd2}] = 18'd0;

        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_outputs");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_all_zero("idle_outputs");

        // Full pass with sum_ready held high: latency and throughput
        sum_ready = 1'b1;
        clear_counts();
        push_pass();
        pulse_start();
        n1 = 0;
        do begin
            @(negedge clk);
            n1++;
            if (n1 == 1) chk("first_fc_rd", 64'({fc_rd_en, fc_addr}), 64'({1'b1, 6'd0}));
        end while (!sum_valid && n1 < 50);
        chk("latency_cycles", 64'(n1), 64'd7);
        wait_done(500, n2);
        chk("pass_cycles", 64'(n1 + n2), 64'(NF * 7 + 1));
        check_pass_counts();

        // Backpressure on the first result
        sum_ready = 1'b0;
        clear_counts();
        push_pass();
        pulse_start();
        n1 = 0;
        do begin
            @(negedge clk);
            n1++;
        end while (!sum_valid && n1 < 50);
        chk("bp_valid_seen", 64'(sum_valid), 64'd1);
        repeat (20) @(negedge clk);
        chk("bp_still_valid", 64'(sum_valid), 64'd1);
        @(posedge clk); #1 sum_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_issue", 64'({fc_rd_en, fc_addr}), 64'({1'b1, 6'd4}));
        wait_done(500, n2);
        check_pass_counts();

        // Reset during feature 3, corner 2
        clear_counts();
        push_pass();
        pulse_start();
        n1 = 0;
        do begin
            @(negedge clk);
            n1++;
        end while (!(fc_rd_en && fc_addr == 6'd14) && n1 < 200);
        chk("reached_f3_k2", 64'(fc_addr), 64'd14);
        reset_n = 1'b0;
        #1 check_all_zero("reset_async");
        @(posedge clk); #1 check_all_zero("reset_next_edge");
        sb_q.delete();
        @(posedge clk); #1 reset_n = 1'b1;

        // Restart after reset, with an out-of-range corner in feature 5
        saved = fc_mem[21];
        fc_mem[21] = {5'd25, 5'd3};
        clear_counts();
        push_pass();
        pulse_start();
        @(negedge clk);
        chk("restart_addr0", 64'({fc_rd_en, fc_addr}), 64'({1'b1, 6'd0}));
        wait_done(500, n2);
        check_pass_counts();
`ifdef FEATURE_RECT_COORD_CHECK_EN
        exp_ce = 1'b1;
`else
        exp_ce = 1'b0;
`endif
        chk("coord_err_set", 64'(coord_err), 64'(exp_ce));
        repeat (5) @(negedge clk);
        chk("coord_err_sticky", 64'(coord_err), 64'(exp_ce));
        fc_mem[21] = saved;

        // Random backpressure pass
        clear_counts();
        push_pass();
        pulse_start();
        n1 = 0;
        do begin
            @(posedge clk); #1 sum_ready = 1'($urandom);
            @(negedge clk);
            n1++;
        end while (!done && n1 < 3000);
        chk("rand_done_seen", 64'(done), 64'd1);
        sum_ready = 1'b1;
        check_pass_counts();
        chk("rand_coord_err", 64'(coord_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
